// File: rtl/rpu_dma_wr_arbiter.sv
// Round-robin, burst-locked arbiter that lets N_REQ masters share one DMA write-command port.
// A grant is held until the beat carrying last=1 is accepted, so bursts never interleave.
module rpu_dma_wr_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 128,
    parameter int STRB_WIDTH = 16,
    parameter int ADDR_WIDTH = 26,
    parameter int HDR_AWIDTH = 24,
    parameter int MAX_BEATS  = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             s_wr_en,
    input  logic [N_REQ*ADDR_WIDTH-1:0]  s_wr_addr,
    input  logic [N_REQ-1:0]             s_hdr_wr_en,
    input  logic [N_REQ*HDR_AWIDTH-1:0]  s_hdr_wr_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]  s_wr_data,
    input  logic [N_REQ*STRB_WIDTH-1:0]  s_wr_strb,
    input  logic [N_REQ-1:0]             s_wr_last,
    output logic [N_REQ-1:0]             s_wr_ready,
    output logic                         m_wr_en,
    output logic [ADDR_WIDTH-1:0]        m_wr_addr,
    output logic                         m_hdr_wr_en,
    output logic [HDR_AWIDTH-1:0]        m_hdr_wr_addr,
    output logic [DATA_WIDTH-1:0]        m_wr_data,
    output logic [STRB_WIDTH-1:0]        m_wr_strb,
    output logic                         m_wr_last,
    input  logic                         m_wr_ready,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         burst_err
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int BW   = $clog2(MAX_BEATS + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            burst_err_q, burst_err_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    rr_offset;
    logic [ID_W:0]      pick_sum;
    logic [ID_W-1:0]    arb_pick;
    logic               beat_accept;

    // Rotate the request vector so bit 0 is rr_ptr, find the lowest set bit, then un-rotate.
    always_comb begin
        req_dbl   = {s_wr_en, s_wr_en} >> rr_ptr_q;
        req_rot   = req_dbl[N_REQ-1:0];
        rr_offset = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) rr_offset = ID_W'(k);
        end
        pick_sum = {1'b0, rr_ptr_q} + {1'b0, rr_offset};
        if (pick_sum >= (ID_W+1)'(N_REQ)) pick_sum = pick_sum - (ID_W+1)'(N_REQ);
        arb_pick = pick_sum[ID_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    assign beat_accept = m_wr_en & m_wr_ready;

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        burst_err_d = burst_err_q;
        case (state_q)
            IDLE: begin
                if (|s_wr_en) begin
                    grant_id_d = arb_pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (beat_accept) begin
                    if (m_wr_last) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                        rr_ptr_d   = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                    end else begin
                        // Overlong bursts are flagged but keep the grant so the stream stays intact.
                        if (beat_cnt_q == BW'(MAX_BEATS - 1)) burst_err_d = 1'b1;
                        if (beat_cnt_q != BW'(MAX_BEATS)) beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_wr_en       = 1'b0;
        m_wr_addr     = '0;
        m_hdr_wr_en   = 1'b0;
        m_hdr_wr_addr = '0;
        m_wr_data     = '0;
        m_wr_strb     = '0;
        m_wr_last     = 1'b0;
        s_wr_ready    = '0;
        busy          = (state_q == BURST);
        grant_id      = grant_id_q;
        burst_err     = burst_err_q;
        if (state_q == BURST) begin
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_id_q == ID_W'(k)) begin
                    m_wr_en       = s_wr_en[k];
                    m_wr_addr     = s_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                    m_hdr_wr_en   = s_hdr_wr_en[k];
                    m_hdr_wr_addr = s_hdr_wr_addr[k*HDR_AWIDTH +: HDR_AWIDTH];
                    m_wr_data     = s_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                    m_wr_strb     = s_wr_strb[k*STRB_WIDTH +: STRB_WIDTH];
                    m_wr_last     = s_wr_last[k];
                    s_wr_ready[k] = m_wr_ready;
                end
            end
        end
    end

endmodule
